// File: rtl/adc_intf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_intf_pkg
// Description : Shared constants and the saturating gain-shift helpers for the
//               ADC front-end (decimator, gain pipeline, FWFT FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
package adc_intf_pkg;

    localparam logic [2:0] c_gain_limit  = 3'd4;
    localparam int         c_dec_ratio_w = 4;

    // Sign-extend a width-bit component to 64 bits and apply the gain shift;
    // gain codes above the limit mean "no shift".
    function automatic logic signed [63:0] gain_ext_shl(
        input logic [63:0] value,
        input logic [2:0]  shift,
        input int          width
    );
        logic signed [63:0] v_ext;
        int                 g;
        g     = (shift > c_gain_limit) ? 0 : int'(shift);
        v_ext = $signed(value << (64 - width)) >>> (64 - width);
        return v_ext <<< g;
    endfunction

    function automatic logic sat_ovf(
        input logic [63:0] value,
        input logic [2:0]  shift,
        input int          width
    );
        logic signed [63:0] v_top;
        v_top = gain_ext_shl(value, shift, width) >>> (width - 1);
        return (v_top != 64'sd0) && (v_top != -64'sd1);
    endfunction

    function automatic logic [63:0] sat_shl(
        input logic [63:0] value,
        input logic [2:0]  shift,
        input int          width
    );
        logic signed [63:0] v_shl;
        logic signed [63:0] v_top;
        logic signed [63:0] v_lim;
        v_shl = gain_ext_shl(value, shift, width);
        v_top = v_shl >>> (width - 1);
        v_lim = 64'sd1 <<< (width - 1);
        if (v_top > 64'sd0) begin
            return $unsigned(v_lim - 64'sd1);
        end
        if (v_top < -64'sd1) begin
            return $unsigned(v_lim);
        end
        return $unsigned(v_shl);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. Writes while full
//               are dropped unless a pop happens in the same cycle; pops while
//               empty are ignored. dout reads 0 while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     wr_en,
    output logic [WIDTH-1:0]         dout,
    input  logic                     rd_en,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [c_aw:0]    w_level;
    logic             w_pop;
    logic             w_push;

    // Pointers carry one extra MSB so a full FIFO reads as level == DEPTH.
    assign w_level = r_wr_ptr - r_rd_ptr;
    assign empty   = (w_level == '0);
    assign full    = w_level[c_aw];
    assign level   = w_level;
    assign w_pop   = rd_en & ~empty;
    assign w_push  = wr_en & (~full | w_pop);
    assign dout    = empty ? '0 : r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_intf_dec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : adc_intf_dec_fifo
// Description : ADC front-end: runtime decimator, saturating gain shift stage
//               and FWFT FIFO towards the baseband, with overflow accounting.
//               Optional macro ADC_INTF_SAT_CNT_EN adds the sat_cnt output.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_intf_dec_fifo
    import adc_intf_pkg::*;
#(
    parameter int IQ_DATA_WIDTH = 16,
    parameter int NUM_CH        = 2,
    parameter int FIFO_DEPTH    = 32,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                                 adc_clk,
    input  logic                                 adc_rst,
    input  logic [2*NUM_CH*IQ_DATA_WIDTH-1:0]    adc_data,
    input  logic                                 adc_valid,
    input  logic [c_dec_ratio_w-1:0]             dec_ratio,
    input  logic [2:0]                           bb_gain,
    input  logic                                 clr_cnt,
    output logic [2*NUM_CH*IQ_DATA_WIDTH-1:0]    data_to_bb,
    output logic                                 emptyn_to_bb,
    input  logic                                 bb_ask_data,
    output logic [$clog2(FIFO_DEPTH):0]          fifo_level,
`ifdef ADC_INTF_SAT_CNT_EN
    output logic [CNT_WIDTH-1:0]                 sat_cnt,
`endif
    output logic [CNT_WIDTH-1:0]                 overflow_cnt
);

    localparam int                   c_n_comp  = 2 * NUM_CH;
    localparam int                   c_data_w  = c_n_comp * IQ_DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic [c_dec_ratio_w-1:0] r_dec_cnt;
    logic                     w_keep;
    logic                     r_s1_valid;
    logic [c_data_w-1:0]      r_s1_data;
    logic                     r_s2_valid;
    logic [c_data_w-1:0]      r_s2_data;
    logic [c_data_w-1:0]      w_gain_data;
    logic                     w_empty;
    logic                     w_full;
    logic                     w_drop;
    logic [CNT_WIDTH-1:0]     r_overflow_cnt;

    // A ratio lowered below the running count keeps the very next sample.
    assign w_keep = adc_valid && (r_dec_cnt >= dec_ratio);

    always_ff @(posedge adc_clk) begin
        if (adc_rst) begin
            r_dec_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_keep;
            r_s2_valid <= r_s1_valid;
            if (adc_valid) begin
                r_dec_cnt <= w_keep ? '0 : r_dec_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge adc_clk) begin
        if (w_keep) begin
            r_s1_data <= adc_data;
        end
        if (r_s1_valid) begin
            r_s2_data <= w_gain_data;
        end
    end

    for (genvar k = 0; k < c_n_comp; k++) begin : g_comp
        logic [IQ_DATA_WIDTH-1:0] w_comp_gain;
        assign w_comp_gain = IQ_DATA_WIDTH'(sat_shl(
            64'(r_s1_data[k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH]), bb_gain, IQ_DATA_WIDTH));
        assign w_gain_data[k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH] = w_comp_gain;
    end

    sync_fifo_fwft #(
        .WIDTH (c_data_w),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (adc_clk),
        .rst   (adc_rst),
        .din   (r_s2_data),
        .wr_en (r_s2_valid),
        .dout  (data_to_bb),
        .rd_en (bb_ask_data),
        .empty (w_empty),
        .full  (w_full),
        .level (fifo_level)
    );

    assign emptyn_to_bb = ~w_empty;
    assign w_drop       = r_s2_valid & w_full & ~bb_ask_data;

    always_ff @(posedge adc_clk) begin
        if (adc_rst || clr_cnt) begin
            r_overflow_cnt <= '0;
        end else if (w_drop && (r_overflow_cnt != c_cnt_max)) begin
            r_overflow_cnt <= r_overflow_cnt + 1'b1;
        end
    end

    assign overflow_cnt = r_overflow_cnt;

`ifdef ADC_INTF_SAT_CNT_EN
    logic [c_n_comp-1:0]  w_sat;
    logic [CNT_WIDTH-1:0] r_sat_cnt;

    for (genvar k = 0; k < c_n_comp; k++) begin : g_sat
        assign w_sat[k] = sat_ovf(
            64'(r_s1_data[k*IQ_DATA_WIDTH +: IQ_DATA_WIDTH]), bb_gain, IQ_DATA_WIDTH);
    end

    always_ff @(posedge adc_clk) begin
        if (adc_rst || clr_cnt) begin
            r_sat_cnt <= '0;
        end else if (r_s1_valid && (|w_sat) && (r_sat_cnt != c_cnt_max)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/adc_intf_dec_fifo.md
Name: adc_intf_dec_fifo

Overview:
Parametrised next-generation ADC front-end on the single adc_clk domain. Takes NUM_CH I/Q channels, decimates by a runtime ratio, applies a per-sample saturating gain shift and buffers into a first-word-fall-through (FWFT) synchronous FIFO for the baseband.
Adds overflow accounting and a fill-level report. Sits between the AD9361 sample bus and the rx baseband, with both in the adc_clk domain.

Parameters:
IQ_DATA_WIDTH, 16, width of one I or Q component (two's complement)
NUM_CH, 2, number of antenna channels; a sample word carries 2*NUM_CH components
FIFO_DEPTH, 32, FIFO entries; power of 2, at least 4
CNT_WIDTH, 16, width of the event counters

Ports:
adc_clk  in  1  sole clock
adc_rst  in  1  synchronous, active-high reset
adc_data  in  2*NUM_CH*IQ_DATA_WIDTH  packed components; component k at bits [(k+1)*IQ_DATA_WIDTH-1 : k*IQ_DATA_WIDTH]
adc_valid  in  1  adc_data qualifier
dec_ratio  in  4  keep 1 of every dec_ratio+1 valid samples
bb_gain  in  3  left shift 0..4; values 5..7 mean 0
clr_cnt  in  1  synchronous clear of the event counters
data_to_bb  out  2*NUM_CH*IQ_DATA_WIDTH  FIFO head word; 0 when empty
emptyn_to_bb  out  1  FIFO not empty
bb_ask_data  in  1  pop request
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow_cnt  out  CNT_WIDTH  samples dropped because the FIFO was full; saturating

Behaviour:
- Reset (adc_rst=1 at a rising edge):
  - dec counter=0, pipeline valids=0, FIFO empty (pointers 0).
  - data_to_bb=0, emptyn_to_bb=0, fifo_level=0, counters=0.
  - Reset mid-operation discards all buffered data.
- Decimation:
  - On each adc_valid=1: if dec_cnt>=dec_ratio, the sample is kept and dec_cnt<=0; otherwise dec_cnt<=dec_cnt+1.
  - dec_ratio=0 passes every sample. dec_ratio=1 keeps the 2nd, 4th, ... (40->20 Msps).
  - Lowering dec_ratio below the current dec_cnt keeps the next valid sample.
  - adc_valid=0 holds dec_cnt.
- Pipeline:
  - S1 registers the kept sample and its valid at edge k.
  - S2 registers the gain-shifted word at edge k+1.
  - The FIFO write occurs at edge k+2; emptyn_to_bb rises after edge k+2 when the FIFO was empty.
  - bb_gain and dec_ratio are used as sampled at the S2 and S1 edges respectively; there is no extra synchronisation.
- Gain:
  - Each component is shifted left by g=bb_gain (g>4 gives 0).
  - If the top g+1 bits of the input are not all equal, the component saturates to +max (0x7FFF for width 16) or -max (0x8000) according to the input sign.
  - Otherwise the result is the input shifted left with zero fill. Components are independent.
- FIFO (FWFT):
  - data_to_bb = mem[rd_ptr] while not empty.
  - A pop occurs when bb_ask_data=1 and emptyn_to_bb=1. bb_ask_data while empty is ignored, with no underflow state change.
  - Write while full without a same-cycle pop: the word is dropped and overflow_cnt increments (holds at 2^CNT_WIDTH-1).
  - Write while full with a same-cycle pop: the write is accepted and the level is unchanged.
  - Simultaneous write and pop at level 1: the head advances to the new word and emptyn stays 1.
  - Pointers wrap modulo FIFO_DEPTH. fifo_level = wr_ptr-rd_ptr, using the extra MSB to tell full from empty.
- clr_cnt=1 zeroes the counters; clear wins over a same-cycle increment.

Optional Feature:
Macro ADC_INTF_SAT_CNT_EN.
- Defined: adds output sat_cnt (CNT_WIDTH). It increments by 1 per S2 word in which at least one component saturated; it saturates at max and is cleared by clr_cnt and adc_rst.
- Undefined: no port and no logic; saturation behaviour is unchanged.

Decomposition:
- Package adc_intf_pkg holds:
  - function sat_shl(value, shift, width) for the saturating left shift;
  - localparams for the gain-code limit (4) and the dec_ratio width (4).
- Sub-module sync_fifo_fwft is parametrised by width and depth. It has ports din/wr_en/dout/rd_en/empty/full/level, with drop-on-full and pop-while-empty ignored.
- The top level holds the decimator, the S1/S2 pipeline and the counters.

Test Plan:
- dec_ratio=1, bb_gain=0, adc_valid continuous, data = incrementing 0,1,2,... -> FIFO receives 1,3,5,...; first emptyn_to_bb=1 follows the edge k+2 after the sample-1 capture.
- bb_gain=3 with component 0x0FFF -> 0x7FF8; 0x1000 -> 0x7FFF; 0xF000 -> 0x8000; 0xEFFF -> 0x8000; bb_gain=6 -> values unchanged.
- bb_ask_data=0, dec_ratio=0, 40 valid samples -> fifo_level=32; last 8 samples lost; overflow_cnt=8; clr_cnt pulse -> 0.
- FIFO full, write and bb_ask_data in the same cycle -> level stays 32, overflow_cnt unchanged, head advances; next pops return in-order data across the pointer wrap.
- adc_rst asserted with 10 entries buffered -> next cycle emptyn_to_bb=0, data_to_bb=0, fifo_level=0; the stream restarts with the first kept sample at dec_cnt=0.
- ADC_INTF_SAT_CNT_EN defined, 5 words each with one saturating component plus 5 clean words -> sat_cnt=5.
